// File: rtl/sram_pkg.sv
// Shared types and default sizes for the banked SRAM line responder.
package sram_pkg;
  localparam int BITWIDTH_D = 256;
  localparam int WIDTH_D    = 16;

  typedef logic [BITWIDTH_D-1:0][WIDTH_D-1:0] line_t;

  typedef enum logic {INIT, RUN} state_t;
endpackage

// File: rtl/sram_array.sv
// DEPTH x line storage: one synchronous write port, one registered read-first read port.
module sram_array
  import sram_pkg::*;
#(
  parameter int BITWIDTH = BITWIDTH_D,
  parameter int WIDTH    = WIDTH_D,
  parameter int DEPTH    = 64,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           we,
  input  logic [AW-1:0]                  waddr,
  input  logic [BITWIDTH-1:0][WIDTH-1:0] wdata,
  input  logic                           re,
  input  logic [AW-1:0]                  raddr,
  output logic [BITWIDTH-1:0][WIDTH-1:0] rdata
);

  logic [BITWIDTH-1:0][WIDTH-1:0] mem [DEPTH];

  // Both updates are non-blocking, so a same-edge read sees the old contents.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sram_bank_responder.sv
// Line-wide SRAM responder: zero-fills on reset/clear, then serves 1-cycle reads
// through a one-entry response register and absorbs writes.
//
// state | meaning
// INIT  | zero-filling line init_cnt each cycle, no traffic accepted
// RUN   | serving reads and writes
module sram_bank_responder
  import sram_pkg::*;
#(
  parameter int BITWIDTH = BITWIDTH_D,
  parameter int WIDTH    = WIDTH_D,
  parameter int DEPTH    = 64
) (
  input  logic                           CKL_i,
  input  logic                           RST_i,
  input  logic                           clear_i,
  output logic                           init_done_o,
  input  logic                           wr_valid_i,
  output logic                           wr_ready_o,
  input  logic [WIDTH-1:0]               wr_addr_i,
  input  logic [BITWIDTH-1:0][WIDTH-1:0] wr_data_i,
  input  logic                           rd_req_valid_i,
  output logic                           rd_req_ready_o,
  input  logic [WIDTH-1:0]               rd_addr_i,
  output logic                           rd_resp_valid_o,
  input  logic                           rd_resp_ready_i,
  output logic [BITWIDTH-1:0][WIDTH-1:0] rd_resp_data_o,
  output logic                           rd_resp_err_o,
  output logic                           addr_err_o
);

  localparam int AW = $clog2(DEPTH);

  state_t                         state, state_n;
  logic [AW-1:0]                  init_cnt, init_cnt_n;
  logic                           run;
  logic                           wr_in_range, rd_in_range;
  logic                           wr_accept, rd_accept;
  logic                           resp_valid, resp_err;
  logic                           arr_we, arr_re;
  logic [AW-1:0]                  arr_waddr;
  logic [BITWIDTH-1:0][WIDTH-1:0] arr_wdata, arr_rdata;

  assign run         = (state == RUN);
  assign wr_in_range = ((wr_addr_i >> AW) == '0);
  assign rd_in_range = ((rd_addr_i >> AW) == '0);

  assign init_done_o    = run;
  assign wr_ready_o     = run;
  assign rd_req_ready_o = run && (!resp_valid || rd_resp_ready_i);
  assign wr_accept      = wr_valid_i && wr_ready_o;
  assign rd_accept      = rd_req_valid_i && rd_req_ready_o;

  always_comb begin
    state_n    = state;
    init_cnt_n = init_cnt;
    case (state)
      INIT: begin
        if (clear_i) begin
          init_cnt_n = '0;
        end else if (init_cnt == AW'(DEPTH - 1)) begin
          state_n    = RUN;
          init_cnt_n = '0;
        end else begin
          init_cnt_n = init_cnt + 1'b1;
        end
      end
      RUN: begin
        if (clear_i) begin
          state_n    = INIT;
          init_cnt_n = '0;
        end
      end
      default: begin
        state_n    = INIT;
        init_cnt_n = '0;
      end
    endcase
  end

  always_ff @(posedge CKL_i or posedge RST_i) begin
    if (RST_i) begin
      state      <= INIT;
      init_cnt   <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      addr_err_o <= 1'b0;
    end else begin
      state    <= state_n;
      init_cnt <= init_cnt_n;
      if (!run || clear_i) begin
        resp_valid <= 1'b0;
        resp_err   <= 1'b0;
        addr_err_o <= 1'b0;
      end else begin
        // Response slot refills whenever it is free or being drained this cycle.
        if (rd_req_ready_o) begin
          resp_valid <= rd_req_valid_i;
          resp_err   <= rd_req_valid_i && !rd_in_range;
        end
        if ((rd_accept && !rd_in_range) || (wr_accept && !wr_in_range))
          addr_err_o <= 1'b1;
      end
    end
  end

  assign arr_we    = run ? (wr_accept && wr_in_range) : 1'b1;
  assign arr_waddr = run ? wr_addr_i[AW-1:0] : init_cnt;
  assign arr_wdata = run ? wr_data_i : '0;
  assign arr_re    = rd_accept && rd_in_range;

  sram_array #(
    .BITWIDTH (BITWIDTH),
    .WIDTH    (WIDTH),
    .DEPTH    (DEPTH)
  ) u_array (
    .clk   (CKL_i),
    .we    (arr_we),
    .waddr (arr_waddr),
    .wdata (arr_wdata),
    .re    (arr_re),
    .raddr (rd_addr_i[AW-1:0]),
    .rdata (arr_rdata)
  );

  assign rd_resp_data_o = (resp_valid && !resp_err) ? arr_rdata : '0;
  assign rd_resp_err_o  = resp_valid && resp_err;
  assign rd_resp_valid_o = resp_valid;

endmodule

// File: tb/tb_sram_bank_responder.sv
// Directed self-checking bench for sram_bank_responder at default sizes.
module tb_sram_bank_responder;
  import sram_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_addr = '0;
  line_t       wr_data = '0;
  logic        rd_req_valid = 1'b0;
  logic [15:0] rd_addr = '0;
  logic        rd_resp_ready = 1'b0;

  logic  init_done, wr_ready, rd_req_ready, rd_resp_valid, rd_resp_err, addr_err;
  line_t rd_resp_data;

  int n_checks = 0;
  int n_errors = 0;

  sram_bank_responder dut (
    .CKL_i           (clk),
    .RST_i           (rst),
    .clear_i         (clear),
    .init_done_o     (init_done),
    .wr_valid_i      (wr_valid),
    .wr_ready_o      (wr_ready),
    .wr_addr_i       (wr_addr),
    .wr_data_i       (wr_data),
    .rd_req_valid_i  (rd_req_valid),
    .rd_req_ready_o  (rd_req_ready),
    .rd_addr_i       (rd_addr),
    .rd_resp_valid_o (rd_resp_valid),
    .rd_resp_ready_i (rd_resp_ready),
    .rd_resp_data_o  (rd_resp_data),
    .rd_resp_err_o   (rd_resp_err),
    .addr_err_o      (addr_err)
  );

  always #5 clk = ~clk;

  function automatic line_t fill(input logic [15:0] v);
    line_t l;
    for (int i = 0; i < BITWIDTH_D; i++) l[i] = v;
    return l;
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_line(input string tag, input line_t obs, input line_t exp);
    int idx = 0;
    for (int i = BITWIDTH_D - 1; i >= 0; i--) if (obs[i] !== exp[i]) idx = i;
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed elem[%0d]=%h expected %h", tag, idx, obs[idx], exp[idx]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (!init_done && n < 100) begin
      tick();
      n++;
    end
    chk_int(tag, n, 64);
  endtask

  task automatic write_line(input logic [15:0] a, input line_t d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic read_line(input logic [15:0] a, input line_t exp, input logic exp_err,
                           input string tag);
    rd_req_valid  = 1'b1;
    rd_addr       = a;
    rd_resp_ready = 1'b1;
    chk({tag, "_req_ready"}, rd_req_ready, 1'b1);
    tick();
    rd_req_valid = 1'b0;
    chk({tag, "_valid"}, rd_resp_valid, 1'b1);
    chk_line({tag, "_data"}, rd_resp_data, exp);
    chk({tag, "_err"}, rd_resp_err, exp_err);
    tick();
    chk({tag, "_drained"}, rd_resp_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b0);
    chk("rst_rd_req_ready", rd_req_ready, 1'b0);
    chk("rst_resp_valid", rd_resp_valid, 1'b0);
    chk("rst_resp_err", rd_resp_err, 1'b0);
    chk("rst_addr_err", addr_err, 1'b0);
    chk_line("rst_resp_data", rd_resp_data, '0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk("init_wr_ready", wr_ready, 1'b0);
    chk("init_rd_req_ready", rd_req_ready, 1'b0);
    // One INIT edge already consumed above, so 63 more remain.
    begin
      int n = 1;
      while (!init_done && n < 100) begin
        tick();
        n++;
      end
      chk_int("init_length", n, 64);
    end
    chk("run_wr_ready", wr_ready, 1'b1);

    read_line(16'd0,  '0, 1'b0, "zero0");
    read_line(16'd31, '0, 1'b0, "zero31");
    read_line(16'd63, '0, 1'b0, "zero63");

    write_line(16'd5, fill(16'hA5A5));
    read_line(16'd5, fill(16'hA5A5), 1'b0, "rd5");

    // Back-to-back 5, 6, 5
    rd_req_valid = 1'b1; rd_addr = 16'd5; rd_resp_ready = 1'b1;
    tick();
    chk_line("b2b_0", rd_resp_data, fill(16'hA5A5));
    chk("b2b_0_ready", rd_req_ready, 1'b1);
    rd_addr = 16'd6;
    tick();
    chk("b2b_1_valid", rd_resp_valid, 1'b1);
    chk_line("b2b_1", rd_resp_data, '0);
    rd_addr = 16'd5;
    tick();
    rd_req_valid = 1'b0;
    chk("b2b_2_valid", rd_resp_valid, 1'b1);
    chk_line("b2b_2", rd_resp_data, fill(16'hA5A5));
    tick();
    chk("b2b_done", rd_resp_valid, 1'b0);

    // Stall with a pending request behind it
    rd_req_valid = 1'b1; rd_addr = 16'd5; rd_resp_ready = 1'b0;
    tick();
    rd_addr = 16'd6;
    for (int i = 0; i < 4; i++) begin
      chk("stall_valid", rd_resp_valid, 1'b1);
      chk("stall_req_ready", rd_req_ready, 1'b0);
      chk_line("stall_data", rd_resp_data, fill(16'hA5A5));
      if (i < 3) tick();
    end
    rd_resp_ready = 1'b1;
    #1;
    chk("stall_release_ready", rd_req_ready, 1'b1);
    tick();
    rd_req_valid = 1'b0;
    chk("stall_next_valid", rd_resp_valid, 1'b1);
    chk_line("stall_next_data", rd_resp_data, '0);
    tick();

    // Same-cycle write and read of line 9
    wr_valid = 1'b1; wr_addr = 16'd9; wr_data = fill(16'h1234);
    rd_req_valid = 1'b1; rd_addr = 16'd9; rd_resp_ready = 1'b1;
    tick();
    wr_valid = 1'b0; rd_req_valid = 1'b0;
    chk_line("rw9_old", rd_resp_data, '0);
    tick();
    read_line(16'd9, fill(16'h1234), 1'b0, "rw9_new");

    // Out-of-range read and write together
    wr_valid = 1'b1; wr_addr = 16'hFFFF; wr_data = fill(16'hDEAD);
    rd_req_valid = 1'b1; rd_addr = 16'h0040;
    tick();
    wr_valid = 1'b0; rd_req_valid = 1'b0;
    chk("oor_valid", rd_resp_valid, 1'b1);
    chk("oor_err", rd_resp_err, 1'b1);
    chk_line("oor_data", rd_resp_data, '0);
    chk("oor_addr_err", addr_err, 1'b1);
    tick();
    chk("oor_addr_err_sticky", addr_err, 1'b1);
    read_line(16'd63, '0, 1'b0, "oor_line63");
    read_line(16'd0,  '0, 1'b0, "oor_line0");
    read_line(16'd9, fill(16'h1234), 1'b0, "oor_line9");
    chk("oor_addr_err_still", addr_err, 1'b1);

    // Clear while stalled, then reset mid-INIT
    write_line(16'd60, fill(16'h7777));
    rd_req_valid = 1'b1; rd_addr = 16'd5; rd_resp_ready = 1'b0;
    tick();
    rd_req_valid = 1'b0;
    chk("clr_pre_valid", rd_resp_valid, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_valid", rd_resp_valid, 1'b0);
    chk("clr_init_done", init_done, 1'b0);
    chk("clr_addr_err", addr_err, 1'b0);
    chk_line("clr_data", rd_resp_data, '0);
    for (int i = 0; i < 10; i++) tick();
    chk("clr_mid_init", init_done, 1'b0);
    rst = 1'b1;
    #1;
    chk("rst2_init_done", init_done, 1'b0);
    chk("rst2_valid", rd_resp_valid, 1'b0);
    tick();
    rst = 1'b0;
    wait_init("init2_length");
    read_line(16'd5,  '0, 1'b0, "post_rst5");
    read_line(16'd60, '0, 1'b0, "post_rst60");
    chk("post_rst_addr_err", addr_err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_bank_responder.md
Name: sram_bank_responder

Overview:
Memory-side responder for the line-wide SRAM datapath: a banked line store answering read requests and absorbing writes issued by the SRAM controller.
- One line is BITWIDTH x WIDTH bits.
- Reads use a valid/ready request channel and a valid/ready response channel with backpressure.
- After reset or a clear request, an internal sequencer zero-fills the array before accepting traffic.

Parameters:
- BITWIDTH, 256, number of WIDTH-bit elements per line.
- WIDTH, 16, element width in bits; also the address port width.
- DEPTH, 64, number of lines (power of two, >= 2); AW = $clog2(DEPTH) is derived.

Ports:
- CKL_i  input  1  clock, all logic on its rising edge.
- RST_i  input  1  asynchronous active-high reset.
- clear_i  input  1  single-cycle pulse; restarts the zero-fill sequence.
- init_done_o  output  1  high while in RUN.
- wr_valid_i  input  1  write request valid.
- wr_ready_o  output  1  write accepted when valid&&ready.
- wr_addr_i  input  WIDTH  write line address.
- wr_data_i  input  [BITWIDTH-1:0][WIDTH-1:0]  write line data.
- rd_req_valid_i  input  1  read request valid.
- rd_req_ready_o  output  1  read request accepted when valid&&ready.
- rd_addr_i  input  WIDTH  read line address.
- rd_resp_valid_o  output  1  response valid.
- rd_resp_ready_i  input  1  response consumed when valid&&ready.
- rd_resp_data_o  output  [BITWIDTH-1:0][WIDTH-1:0]  read line data.
- rd_resp_err_o  output  1  response belongs to an out-of-range address.
- addr_err_o  output  1  sticky flag: any out-of-range read or write accepted since the last reset or clear.

Behaviour:
- Reset values: init_done_o=0, wr_ready_o=0, rd_req_ready_o=0, rd_resp_valid_o=0, rd_resp_data_o=0, rd_resp_err_o=0, addr_err_o=0.
- Array contents are not reset asynchronously; they are defined only after INIT completes.
- State INIT:
  - init_cnt runs 0..DEPTH-1; the array writes zero to line init_cnt each cycle.
  - Both ready outputs are 0.
  - After the write to DEPTH-1, go to RUN. INIT lasts exactly DEPTH cycles from the first clock edge after RST_i deasserts.
- State RUN:
  - init_done_o=1 and wr_ready_o=1.
  - rd_req_ready_o = !rd_resp_valid_o || rd_resp_ready_i. This is combinational, one-entry output register with pass-through refill.
- clear_i in RUN, or RST_i at any time:
  - go to INIT, init_cnt=0, addr_err_o=0.
  - rd_resp_valid_o drops next cycle (or immediately on RST_i); any pending response is discarded.
- clear_i during INIT restarts init_cnt at 0.
- Address range: an address is valid when addr < DEPTH, i.e. upper WIDTH-AW bits are zero.
  - Out-of-range write: accepted but dropped; sets addr_err_o.
  - Out-of-range read: returns data=0 with rd_resp_err_o=1 and sets addr_err_o.
- Read latency: exactly 1 cycle. A request accepted at edge N gives rd_resp_valid_o=1 with data after edge N, for the cycle following acceptance.
- Response hold: the response holds stable while rd_resp_valid_o && !rd_resp_ready_i. The next request cannot be accepted until the current response is consumed, or is being consumed in the same cycle (back-to-back throughput of 1 per cycle).
- Same-cycle read and write to the same address: read-first, so the response returns the old data. The new data is visible to reads accepted on later cycles.
- Write latency: the array updates at the accepting edge.

Decomposition:
- Package sram_pkg:
  - typedef line_t = logic [BITWIDTH-1:0][WIDTH-1:0].
  - enum state_t {INIT, RUN}.
  - Default constants BITWIDTH_D=256, WIDTH_D=16.
- Sub-module sram_array: DEPTH x line_t storage.
  - One synchronous write port and one synchronous read-first read port.
  - Read enable plus address in; registered data out.
  - Isolates the array so it can be swapped for a macro.

Test Plan:
- Reset release, idle inputs -> init_done_o rises exactly 64 cycles later. Reading addresses 0, 31, 63 then returns all-zero lines with rd_resp_err_o=0.
- Write line 5 = all elements 16'hA5A5, then read 5 with rd_resp_ready_i=1 -> response the cycle after acceptance, all elements 16'hA5A5. Back-to-back reads of 5, 6, 5 give 3 responses in 3 consecutive cycles.
- Hold rd_resp_ready_i=0 for 4 cycles after a read of line 5 -> rd_req_ready_o=0 and data stable for 4 cycles. Raising ready with a new request pending accepts it in that same cycle.
- Same-cycle write of line 9 = 16'h1234 (old value 0) and read of 9 -> response 0. A following read of 9 -> 16'h1234.
- Read address 16'h0040 and write address 16'hFFFF -> read response data 0 with rd_resp_err_o=1; addr_err_o=1 sticky; no in-range line altered.
- clear_i pulse while a response is stalled, then assert RST_i mid-INIT -> response dropped, init_done_o=0, addr_err_o=0. INIT restarts; after 64 cycles line 5 reads 0.
